// File: rtl/frac_clk_ratio_meter.sv
// Edge-count / edge-spacing meter for a toggling signal, measured over a fixed
// window of clk_in cycles. Results are updated with a one-cycle done pulse.
module frac_clk_ratio_meter #(
    parameter int WINDOW      = 48,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] min_gap,
    output logic [CNT_W-1:0] max_gap,
    output logic             overflow
);

    localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] ALL1 = {CNT_W{1'b1}};
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              hist_q;
    logic [WC_W-1:0]   window_q, window_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  min_q, min_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic              ovf_q, ovf_d;
    logic              seen_q, seen_d;
    logic              have_gap_q, have_gap_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]  res_min_q, res_min_d;
    logic [CNT_W-1:0]  res_max_q, res_max_d;
    logic              res_ovf_q, res_ovf_d;

    logic              sync_out;
    logic              edge_w;
    logic [CNT_W-1:0]  gap_v;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // History follows the synchronizer every cycle, so entering MEASURE never sees a stale edge.
    assign edge_w   = sync_out ^ hist_q;
    assign gap_v    = (gap_q == ALL1) ? ALL1 : gap_q + CNT_W'(1);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            window_q   <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            ovf_q      <= 1'b0;
            seen_q     <= 1'b0;
            have_gap_q <= 1'b0;
            res_cnt_q  <= '0;
            res_min_q  <= '0;
            res_max_q  <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q     <= sync_out;
            window_q   <= window_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            ovf_q      <= ovf_d;
            seen_q     <= seen_d;
            have_gap_q <= have_gap_d;
            res_cnt_q  <= res_cnt_d;
            res_min_q  <= res_min_d;
            res_max_q  <= res_max_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        ovf_d      = ovf_q;
        seen_d     = seen_q;
        have_gap_d = have_gap_q;
        res_cnt_d  = res_cnt_q;
        res_min_d  = res_min_q;
        res_max_d  = res_max_q;
        res_ovf_d  = res_ovf_q;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_MEASURE;
                    window_d   = '0;
                    gap_d      = '0;
                    cnt_d      = '0;
                    min_d      = '0;
                    max_d      = '0;
                    ovf_d      = 1'b0;
                    seen_d     = 1'b0;
                    have_gap_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                busy     = 1'b1;
                window_d = window_q + WC_W'(1);
                if (gap_q == ALL1) ovf_d = 1'b1;
                else               gap_d = gap_q + CNT_W'(1);
                if (edge_w) begin
                    if (cnt_q == ALL1) ovf_d = 1'b1;
                    else               cnt_d = cnt_q + CNT_W'(1);
                    if (seen_q) begin
                        if (!have_gap_q || gap_v < min_q) min_d = gap_v;
                        if (!have_gap_q || gap_v > max_q) max_d = gap_v;
                        have_gap_d = 1'b1;
                    end
                    gap_d  = '0;
                    seen_d = 1'b1;
                end
                // Results take the post-update working values so the last cycle's edge is included
                // and they are already valid while done is high.
                if (window_q == WIN_LAST) begin
                    state_d   = ST_DONE;
                    res_cnt_d = cnt_d;
                    res_min_d = min_d;
                    res_max_d = max_d;
                    res_ovf_d = ovf_d;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign toggle_count = res_cnt_q;
    assign min_gap      = res_min_q;
    assign max_gap      = res_max_q;
    assign overflow     = res_ovf_q;

endmodule

// File: tb/tb_frac_clk_ratio_meter.sv
// Bench for frac_clk_ratio_meter: a default-parameter instance (A) and a small
// CNT_W=4 / WINDOW=20 instance (B) that share the monitored signal.
module tb_frac_clk_ratio_meter;

  localparam int WIN_A = 48;
  localparam int WIN_B = 20;
  localparam int EW    = 49;  // {ovf, count, min, max}

  logic clk = 1'b0;
  logic rst_a, rst_b, sig, start_a, start_b;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] tc_a, mn_a, mx_a;
  logic [3:0]  tc_b, mn_b, mx_b;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;        // 0 hold, 1 every 3, 2 gaps 1/2, 3 every cycle, 4 single toggle
  int ph = 0;
  bit single_req = 0;

  always #5 clk = ~clk;

  frac_clk_ratio_meter u_a (
    .clk_in(clk), .reset(rst_a), .sig_in(sig), .start(start_a),
    .busy(busy_a), .done(done_a), .toggle_count(tc_a),
    .min_gap(mn_a), .max_gap(mx_a), .overflow(ovf_a)
  );

  frac_clk_ratio_meter #(.WINDOW(WIN_B), .CNT_W(4), .SYNC_STAGES(2)) u_b (
    .clk_in(clk), .reset(rst_b), .sig_in(sig), .start(start_b),
    .busy(busy_b), .done(done_b), .toggle_count(tc_b),
    .min_gap(mn_b), .max_gap(mx_b), .overflow(ovf_b)
  );

  // Monitored-signal generator, changes away from the active edge.
  always @(negedge clk) begin
    case (mode)
      1: begin if (ph == 2) sig = ~sig; ph = (ph + 1) % 3; end
      2: begin if (ph != 2) sig = ~sig; ph = (ph + 1) % 3; end
      3: sig = ~sig;
      4: if (single_req) begin sig = ~sig; single_req = 0; end
      default: ;
    endcase
  end

  // Scoreboard consumer: pops the oldest expectation and compares each field.
  task automatic sb_check(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: result with empty expected queue got=%h", name, got);
      return;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (got[47:32] !== exp[47:32]) begin
      n_bad++; $display("FAIL %s.count: got %0d expected %0d", name, got[47:32], exp[47:32]);
    end
    n_cmp++;
    if (got[31:16] !== exp[31:16]) begin
      n_bad++; $display("FAIL %s.min_gap: got %0d expected %0d", name, got[31:16], exp[31:16]);
    end
    n_cmp++;
    if (got[15:0] !== exp[15:0]) begin
      n_bad++; $display("FAIL %s.max_gap: got %0d expected %0d", name, got[15:0], exp[15:0]);
    end
    n_cmp++;
    if (got[48] !== exp[48]) begin
      n_bad++; $display("FAIL %s.overflow: got %b expected %b", name, got[48], exp[48]);
    end
  endtask

  task automatic wait_done_a(input int limit, inout int cyc);
    while (done_a !== 1'b1 && cyc < limit) begin @(negedge clk); cyc++; end
  endtask

  task automatic set_mode(input int m);
    mode = m; ph = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    int pulses;
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0; sig = 0;
    #1;
    n_cmp++;
    if ({busy_a, done_a, tc_a, mn_a, mx_a, ovf_a} !== 51'd0) begin
      n_bad++; $display("FAIL reset_a: got busy=%b done=%b cnt=%0d min=%0d max=%0d ovf=%b expected all 0",
                        busy_a, done_a, tc_a, mn_a, mx_a, ovf_a);
    end
    n_cmp++;
    if ({busy_b, done_b, tc_b, mn_b, mx_b, ovf_b} !== 15'd0) begin
      n_bad++; $display("FAIL reset_b: got busy=%b done=%b cnt=%0d ovf=%b expected all 0",
                        busy_b, done_b, tc_b, ovf_b);
    end
    repeat (3) @(negedge clk);
    rst_a = 0; rst_b = 0;
    mode = 1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a || done_b || busy_a || busy_b) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL idle_activity: got %0d busy/done cycles expected 0", pulses);
    end
    n_cmp++;
    if ({tc_a, mn_a, mx_a, ovf_a} !== 49'd0) begin
      n_bad++; $display("FAIL idle_results: got cnt=%0d min=%0d max=%0d ovf=%b expected 0",
                        tc_a, mn_a, mx_a, ovf_a);
    end
  endtask

  // One start pulse on A; checks busy, done latency (cycle WINDOW+1) and results.
  task automatic measure_a(input string name, input int m, input int c, input int mn,
                           input int mx, input bit single);
    int cyc;
    set_mode(m);
    exp_q.push_back({1'b0, 16'(c), 16'(mn), 16'(mx)});
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    cyc = 1;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL %s.busy: got %b expected 1 in cycle 1", name, busy_a);
    end
    if (single) begin
      repeat (19) @(negedge clk);
      cyc += 19;
      single_req = 1;
    end
    wait_done_a(WIN_A + 10, cyc);
    n_cmp++;
    if (cyc !== WIN_A + 1) begin
      n_bad++; $display("FAIL %s.done_cycle: got %0d expected %0d", name, cyc, WIN_A + 1);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL %s.busy_at_done: got %b expected 0", name, busy_a);
    end
    sb_check(name, {ovf_a, tc_a, mn_a, mx_a});
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int cyc, extra;
    set_mode(4);
    exp_q.push_back({1'b0, 16'd1, 16'd0, 16'd0});
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < WIN_A + 10) begin
      start_a = (cyc == 10 || cyc == 30) ? 1'b1 : 1'b0;
      if (cyc == 20) single_req = 1;
      @(negedge clk);
      cyc++;
    end
    start_a = 0;
    n_cmp++;
    if (cyc !== WIN_A + 1) begin
      n_bad++; $display("FAIL ignored_start.done_cycle: got %0d expected %0d", cyc, WIN_A + 1);
    end
    sb_check("single_edge", {ovf_a, tc_a, mn_a, mx_a});
    extra = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL ignored_start.extra_done: got %0d expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    set_mode(1);
    exp_q.push_back({1'b0, 16'd16, 16'd3, 16'd3});
    exp_q.push_back({1'b0, 16'd16, 16'd3, 16'd3});
    start_a = 1;
    @(negedge clk);
    cyc = 1;
    wait_done_a(WIN_A + 10, cyc);
    n_cmp++;
    if (cyc !== WIN_A + 1) begin
      n_bad++; $display("FAIL b2b.first_done: got %0d expected %0d", cyc, WIN_A + 1);
    end
    sb_check("b2b_first", {ovf_a, tc_a, mn_a, mx_a});
    @(negedge clk);
    cyc++;
    wait_done_a(2 * WIN_A + 20, cyc);
    start_a = 0;
    n_cmp++;
    if (cyc !== 2 * WIN_A + 3) begin
      n_bad++; $display("FAIL b2b.second_done: got %0d expected %0d", cyc, 2 * WIN_A + 3);
    end
    sb_check("b2b_second", {ovf_a, tc_a, mn_a, mx_a});
    @(negedge clk);
  endtask

  task automatic test_overflow_and_abort;
    int cyc, pulses;
    set_mode(3);
    exp_q.push_back({1'b1, 16'd15, 16'd1, 16'd1});
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    cyc = 1;
    while (done_b !== 1'b1 && cyc < WIN_B + 10) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc !== WIN_B + 1) begin
      n_bad++; $display("FAIL ovf.done_cycle: got %0d expected %0d", cyc, WIN_B + 1);
    end
    sb_check("overflow", {ovf_b, 12'd0, tc_b, 12'd0, mn_b, 12'd0, mx_b});
    repeat (3) @(negedge clk);
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    repeat (9) @(negedge clk);
    rst_b = 1;
    #1;
    n_cmp++;
    if ({busy_b, done_b, tc_b, mn_b, mx_b, ovf_b} !== 15'd0) begin
      n_bad++; $display("FAIL abort: got busy=%b done=%b cnt=%0d min=%0d max=%0d ovf=%b expected all 0",
                        busy_b, done_b, tc_b, mn_b, mx_b, ovf_b);
    end
    repeat (2) @(negedge clk);
    rst_b = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_b || busy_b) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL abort.no_done: got %0d busy/done cycles expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    measure_a("every3", 1, 16, 3, 3, 1'b0);
    measure_a("div23", 2, 32, 1, 2, 1'b0);
    measure_a("constant", 0, 0, 0, 0, 1'b0);
    measure_a("single", 4, 1, 0, 0, 1'b1);
    test_ignored_start();
    test_back_to_back();
    test_overflow_and_abort();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++; $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
